// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU and LSU,
// plus a pending-write scoreboard that stalls decode on RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [31:0]     alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [31:0]     lsu_data,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_use1,
  input  logic            iss_use2,
  output logic            stall,
  output logic            WE,
  output logic [4:0]      AddD,
  output logic [31:0]     DataD,
  output logic [CNTW-1:0] outstanding
);
  logic            rr_q, rr_d;
  logic            we_q, we_d;
  logic [4:0]      addd_q, addd_d, rd_sel;
  logic [31:0]     datad_q, datad_d;
  logic [NREG-1:0] pend_q, pend_d, set_v, clr_v;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            acc, issue;
  // rr_q=1 means the LSU wins the next contended cycle
  always_comb begin
    alu_ready = alu_valid & (~lsu_valid | ~rr_q);
    lsu_ready = lsu_valid & (~alu_valid | rr_q);
    acc       = alu_ready | lsu_ready;
    rd_sel    = lsu_ready ? lsu_rd : alu_rd;
    rr_d      = (alu_valid & lsu_valid) ? ~rr_q : rr_q;
    we_d      = acc & (rd_sel != 5'd0);
    addd_d    = acc ? rd_sel : addd_q;
    datad_d   = acc ? (lsu_ready ? lsu_data : alu_data) : datad_q;
    stall     = iss_valid & ((iss_use1 & pend_q[iss_rs1]) | (iss_use2 & pend_q[iss_rs2]) | pend_q[iss_rd]);
    issue     = iss_valid & ~stall & (iss_rd != 5'd0);
    set_v     = NREG'(issue) << iss_rd;
    clr_v     = NREG'(we_q) << addd_q;
    pend_d    = ((pend_q & ~clr_v) | set_v) & ~NREG'(1);
    cnt_d     = (issue & ~we_q & (cnt_q != {CNTW{1'b1}})) ? cnt_q + CNTW'(1) :
                (we_q & ~issue & (cnt_q != '0)) ? cnt_q - CNTW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= 1'b1;
      we_q    <= 1'b0;
      addd_q  <= '0;
      datad_q <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      addd_q  <= addd_d;
      datad_q <= datad_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end
  assign WE          = we_q;
  assign AddD        = addd_q;
  assign DataD       = datad_q;
  assign outstanding = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, write latency, scoreboard and reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        iss_use1 = 1'b0, iss_use2 = 1'b0;
  logic        alu_ready, lsu_ready, stall, WE;
  logic [4:0]  AddD;
  logic [31:0] DataD;
  logic [5:0]  outstanding;
  int          total = 0, passed = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .stall(stall),
    .WE(WE), .AddD(AddD), .DataD(DataD), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_we", WE, 0);
    chk("rst_addd", AddD, 0);
    chk("rst_datad", DataD, 0);
    chk("rst_out", outstanding, 0);
    rst = 1'b1;
    // reset mid-stream while WE=1 and a register is pending
    tick();
    iss_valid = 1; iss_rd = 1;
    #1 chk("t1_nostall", stall, 0);
    tick();
    chk("t1_out1", outstanding, 1);
    iss_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'hAAAA;
    tick();
    alu_valid = 0;
    chk("t1_we_pre", WE, 1);
    iss_valid = 1; iss_rd = 2; iss_rs1 = 1; iss_use1 = 1;
    #1 chk("t1_stall_pre", stall, 1);
    #1 rst = 1'b0;
    #1;
    chk("t1_async_we", WE, 0);
    chk("t1_async_out", outstanding, 0);
    chk("t1_async_stall", stall, 0);
    iss_valid = 0; iss_use1 = 0;
    #2 rst = 1'b1;
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h12345678;
    #1 chk("t1_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("t1_we", WE, 1);
    chk("t1_addd", AddD, 5);
    chk("t1_datad", DataD, 32'h12345678);
    tick();
    chk("t1_we_off", WE, 0);
    chk("t1_addd_hold", AddD, 5);
    chk("t1_datad_hold", DataD, 32'h12345678);
    chk("t1_out_sat0", outstanding, 0);
    // contended round robin, LSU first after reset
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_lsu_ready", lsu_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_alu_ready", alu_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_we", WE, 1);
      chk("t2_addd", AddD, (i % 2 == 0) ? 4 : 3);
      chk("t2_datad", DataD, (i % 2 == 0) ? 32'h44 : 32'h33);
    end
    alu_valid = 0; lsu_valid = 0;
    tick();
    chk("t2_we_off", WE, 0);
    // RAW stall on rd=7
    iss_valid = 1; iss_rd = 7; iss_use1 = 0;
    #1 chk("t3_issue_nostall", stall, 0);
    tick();
    chk("t3_out1", outstanding, 1);
    iss_rd = 10; iss_rs1 = 7; iss_use1 = 1;
    #1 chk("t3_raw_stall", stall, 1);
    tick();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    #1 chk("t3_stall_hold", stall, 1);
    chk("t3_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("t3_we", WE, 1);
    chk("t3_addd", AddD, 7);
    chk("t3_stall_wecycle", stall, 1);
    chk("t3_out_wecycle", outstanding, 1);
    tick();
    chk("t3_stall_clear", stall, 0);
    chk("t3_out0", outstanding, 0);
    iss_valid = 0; iss_use1 = 0;
    // rd=0 write is handshaken but suppressed
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    iss_valid = 1; iss_rd = 0; iss_rs1 = 0; iss_use1 = 1;
    #1 chk("t4_alu_ready", alu_ready, 1);
    chk("t4_r0_nostall", stall, 0);
    tick();
    alu_valid = 0; iss_valid = 0; iss_use1 = 0;
    chk("t4_we", WE, 0);
    chk("t4_out", outstanding, 0);
    // set of pending[9] wins over a simultaneous clear
    iss_valid = 1; iss_rd = 11;
    tick();
    iss_valid = 0;
    chk("t5_out1", outstanding, 1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    chk("t5_we", WE, 1);
    chk("t5_addd", AddD, 9);
    iss_valid = 1; iss_rd = 9;
    #1 chk("t5_issue_nostall", stall, 0);
    tick();
    chk("t5_out_unchanged", outstanding, 1);
    iss_rd = 0; iss_rs1 = 9; iss_use1 = 1;
    #1 chk("t5_read9_stall", stall, 1);
    iss_valid = 0; iss_use1 = 0;
    alu_valid = 1; alu_rd = 9;
    tick();
    alu_rd = 11;
    tick();
    alu_valid = 0;
    tick();
    iss_valid = 1; iss_rs1 = 9; iss_use1 = 1; iss_rd = 0;
    #1 chk("t5_read9_free", stall, 0);
    iss_valid = 0; iss_use1 = 0;
    tick();
    chk("t5_out_drain", outstanding, 0);
    // WAW stall on rd=12
    iss_valid = 1; iss_rd = 12;
    #1 chk("t6_first_nostall", stall, 0);
    tick();
    #1 chk("t6_waw_stall", stall, 1);
    tick();
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC;
    #1 chk("t6_waw_hold", stall, 1);
    tick();
    alu_valid = 0;
    chk("t6_we", WE, 1);
    chk("t6_addd", AddD, 12);
    chk("t6_stall_wecycle", stall, 1);
    tick();
    chk("t6_stall_clear", stall, 0);
    chk("t6_out0", outstanding, 0);
    tick();
    iss_valid = 0;
    chk("t6_out_reissue", outstanding, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the RV32I register file.
- Shares the register file's single write port (WE/AddD/DataD) between two producers: the ALU write-back path and the load/store unit (LSU) load-return path.
- Tracks which registers have a write still in flight, and raises a stall to decode when an instruction reads or overwrites one of them.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- CNTW, 6, width of the outstanding-write counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid  in  1  load-return request
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- lsu_ready  out  1  LSU request accepted this cycle
- iss_valid  in  1  decode wants to issue an instruction
- iss_rd  in  5  destination of the issuing instruction
- iss_rs1  in  5  first source register
- iss_rs2  in  5  second source register
- iss_use1  in  1  rs1 is actually read
- iss_use2  in  1  rs2 is actually read
- stall  out  1  issue blocked this cycle
- WE  out  1  register-file write enable (registered)
- AddD  out  5  register-file write address (registered)
- DataD  out  32  register-file write data (registered)
- outstanding  out  CNTW  count of pending register writes

Behaviour:
Reset (rst low, asynchronous):
- WE=0, AddD=0, DataD=0.
- Pending vector = 0, outstanding = 0.
- Round-robin pointer = LSU-preferred.
- Any accepted-but-not-yet-written data is discarded.
- Outputs return to their reset values within the reset assertion, with no clock required.

Arbitration (combinational ready):
- Only one valid requester: it is granted.
- Both valid: grant the requester not granted most recently, then update the pointer.
- Pointer changes only on a contended grant.
- alu_ready / lsu_ready are the grant signals; a transfer occurs on valid & ready.
- Requesters must hold rd/data stable while valid is high and ready is low.
- At most one grant per cycle.

Write path, latency 1:
- An accept at edge N drives WE=1, AddD=rd, DataD=data during cycle N+1.
- The register file commits the write at edge N+1.
- No accept: WE=0 the next cycle; AddD and DataD hold their previous values.
- An accepted request with rd=0 is handshaken (ready=1) but produces WE=0.

Scoreboard:
- pending[r] is set at the edge where iss_valid & !stall & iss_rd!=0, with r = iss_rd.
- pending[r] is cleared at the edge where WE=1 & AddD=r.
- Set and clear of the same register at the same edge: set wins.
- pending[0] is always 0.

Stall (combinational):
- stall = iss_valid & ( (iss_use1 & pending[iss_rs1]) | (iss_use2 & pending[iss_rs2]) | pending[iss_rd] ).
- This covers RAW and WAW hazards. There is no forwarding: a source is readable the cycle after its WE cycle.

Outstanding counter:
- +1 on each successful issue with rd!=0.
- -1 on each WE=1 cycle.
- Both at the same edge: unchanged.
- Saturates at its maximum and at 0, and never wraps.

Producer rd contract:
- Producers must only target registers with pending set.
- A write to a non-pending register is still performed and leaves pending[r]=0.

Test Plan:
1. Reset with rst=0 mid-stream while WE=1 → WE=0, outstanding=0 and stall=0 immediately; after release, the first alu_valid (rd=5, data=0x12345678) → WE=1, AddD=5, DataD=0x12345678 exactly one cycle later.
2. alu_valid and lsu_valid high for 4 consecutive cycles (rd 3 and 4) → grants alternate LSU, ALU, LSU, ALU; WE is high for 4 consecutive cycles with AddD 4, 3, 4, 3.
3. Issue rd=7; next cycle issue with rs1=7, use1=1 → stall=1 until the cycle after WE=1 with AddD=7, then stall=0; outstanding goes 0→1→0.
4. alu_valid with rd=0, data=0xFFFFFFFF → alu_ready=1, WE stays 0, and no pending bit changes.
5. Edge on which WE=1/AddD=9 clears pending[9] coincides with a new issue of rd=9 → pending[9]=1 afterwards; a later instruction reading 9 stalls; outstanding unchanged across that edge.
6. Issue rd=12 and then a second instruction with rd=12 before the write-back → the second is stalled (WAW) until pending[12] clears.
